// File: rtl/pixel_mix_fifo.sv
// Background pixel FIFO plus an 8-slot sprite overlay: drops fine-scroll pixels,
// mixes background and sprite indices through their palettes, emits one scanline.
module pixel_mix_fifo #(
    parameter int PIX_W   = 2,
    parameter int SHADE_W = 2,
    parameter int DEPTH   = 16,
    parameter int X_MAX   = 160,
    parameter int NUM_OBP = 2,
    localparam int PAL_W  = (1 << PIX_W) * SHADE_W,
    localparam int SEL_W  = $clog2(NUM_OBP),
    localparam int X_W    = $clog2(X_MAX + 1)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               tclk_in,
    input  logic               line_start_in,
    input  logic [2:0]         fine_scroll_in,
    input  logic               pause_in,
    input  logic               bg_push_in,
    input  logic [8*PIX_W-1:0] bg_row_in,
    output logic               bg_ready_out,
    input  logic               obj_merge_in,
    input  logic [8*PIX_W-1:0] obj_row_in,
    input  logic [SEL_W-1:0]   obj_pal_in,
    input  logic               obj_prio_in,
    input  logic               bg_enable_in,
    input  logic               obj_enable_in,
    input  logic [PAL_W-1:0]   bgp_in,
    input  logic [PAL_W-1:0]   obp_in [NUM_OBP],
    output logic [SHADE_W-1:0] pixel_out,
    output logic               pixel_valid_out,
    output logic [X_W-1:0]     x_out,
    output logic               line_done_out,
    output logic               overflow_out
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DISCARD, RUN, DONE} state_t;

    typedef struct packed {
        logic [PIX_W-1:0] idx;
        logic [SEL_W-1:0] pal;
        logic             prio;
    } slot_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   bg_count_reg, bg_count_next;
    logic [PIX_W-1:0]   bg_q_reg [DEPTH];
    logic [PIX_W-1:0]   bg_q_next [DEPTH];
    slot_t              ovl_reg [8];
    slot_t              ovl_next [8];
    logic [2:0]         discard_reg, discard_next;
    logic [X_W-1:0]     x_reg, x_next;
    logic [SHADE_W-1:0] pixel_reg, pixel_next;
    logic               valid_reg, valid_next;
    logic               done_reg, done_next;
    logic               overflow_reg, overflow_next;

    logic [PIX_W-1:0]   bg_pix [8];
    logic [PIX_W-1:0]   obj_pix [8];
    logic [SHADE_W-1:0] bgp_shade [1 << PIX_W];
    logic [SHADE_W-1:0] obp_shade [NUM_OBP][1 << PIX_W];

    logic               start, active, pop_en, push_ok, push_drop, merge_ok;
    logic [CNT_W-1:0]   wr_base;

    genvar gi, gj;

    // Unpack rows (pixel 0 sits in the MSBs) and palettes into index-addressable arrays
    generate
        for (gi = 0; gi < 8; gi++) begin : g_row
            assign bg_pix[gi]  = bg_row_in[(7-gi)*PIX_W +: PIX_W];
            assign obj_pix[gi] = obj_row_in[(7-gi)*PIX_W +: PIX_W];
        end
        for (gi = 0; gi < (1 << PIX_W); gi++) begin : g_pal
            assign bgp_shade[gi] = bgp_in[gi*SHADE_W +: SHADE_W];
            for (gj = 0; gj < NUM_OBP; gj++) begin : g_obp
                assign obp_shade[gj][gi] = obp_in[gj][gi*SHADE_W +: SHADE_W];
            end
        end
    endgenerate

    assign bg_ready_out = (bg_count_reg <= CNT_W'(DEPTH - 8));
    assign start        = tclk_in & line_start_in;
    assign active       = (state_reg == DISCARD) || (state_reg == RUN);
    assign pop_en       = tclk_in & ~line_start_in & active & (bg_count_reg != '0)
                          & ~pause_in & ~obj_merge_in;
    assign push_ok      = tclk_in & ~line_start_in & bg_push_in & bg_ready_out;
    assign push_drop    = tclk_in & ~line_start_in & bg_push_in & ~bg_ready_out;
    assign merge_ok     = tclk_in & ~line_start_in & obj_merge_in;
    // A new row lands directly behind whatever survives this cycle's pop
    assign wr_base      = bg_count_reg - CNT_W'(pop_en);

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fifo
            logic [CNT_W:0]   rel;
            logic [PIX_W-1:0] shifted;
            assign rel = (CNT_W+1)'(gi) - {1'b0, wr_base};
            if (gi == DEPTH - 1) begin : g_last
                assign shifted = pop_en ? '0 : bg_q_reg[gi];
            end else begin : g_mid
                assign shifted = pop_en ? bg_q_reg[gi+1] : bg_q_reg[gi];
            end
            assign bg_q_next[gi] = (push_ok && rel < (CNT_W+1)'(8)) ? bg_pix[rel[2:0]] : shifted;
        end

        for (gi = 0; gi < 8; gi++) begin : g_ovl
            slot_t shifted, merged;
            if (gi == 7) begin : g_tail
                assign shifted = '0;
            end else begin : g_body
                assign shifted = ovl_reg[gi+1];
            end
            // Only transparent slots accept a sprite pixel, so the first sprite merged wins
            assign merged = (ovl_reg[gi].idx == '0 && obj_pix[gi] != '0)
                            ? {obj_pix[gi], obj_pal_in, obj_prio_in} : ovl_reg[gi];
            assign ovl_next[gi] = start ? '0 : pop_en ? shifted : merge_ok ? merged : ovl_reg[gi];
        end
    endgenerate

    logic [PIX_W-1:0]   mix_b, mix_o;
    logic               use_obj;
    logic [SHADE_W-1:0] mix_shade;

    assign mix_b     = bg_enable_in ? bg_q_reg[0] : '0;
    assign mix_o     = obj_enable_in ? ovl_reg[0].idx : '0;
    assign use_obj   = (mix_o != '0) && (!ovl_reg[0].prio || mix_b == '0);
    assign mix_shade = use_obj ? obp_shade[ovl_reg[0].pal][mix_o] : bgp_shade[mix_b];

    always_comb begin
        state_next    = state_reg;
        bg_count_next = bg_count_reg;
        discard_next  = discard_reg;
        x_next        = x_reg;
        pixel_next    = pixel_reg;
        valid_next    = 1'b0;
        done_next     = 1'b0;
        overflow_next = overflow_reg;
        if (start) begin
            bg_count_next = '0;
            x_next        = '0;
            overflow_next = 1'b0;
            discard_next  = fine_scroll_in;
            state_next    = (fine_scroll_in != 3'd0) ? DISCARD : RUN;
        end else begin
            if (push_drop) begin
                overflow_next = 1'b1;
            end
            bg_count_next = wr_base + (push_ok ? CNT_W'(8) : CNT_W'(0));
            if (pop_en) begin
                if (state_reg == DISCARD) begin
                    discard_next = discard_reg - 3'd1;
                    if (discard_reg == 3'd1) begin
                        state_next = RUN;
                    end
                end else begin
                    valid_next = 1'b1;
                    pixel_next = mix_shade;
                    x_next     = x_reg + X_W'(1);
                    if (x_reg == X_W'(X_MAX - 1)) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            bg_count_reg <= '0;
            discard_reg  <= '0;
            x_reg        <= '0;
            pixel_reg    <= '0;
            valid_reg    <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) bg_q_reg[i] <= '0;
            for (int i = 0; i < 8; i++) ovl_reg[i] <= '0;
        end else begin
            state_reg    <= state_next;
            bg_count_reg <= bg_count_next;
            discard_reg  <= discard_next;
            x_reg        <= x_next;
            pixel_reg    <= pixel_next;
            valid_reg    <= valid_next;
            done_reg     <= done_next;
            overflow_reg <= overflow_next;
            for (int i = 0; i < DEPTH; i++) bg_q_reg[i] <= bg_q_next[i];
            for (int i = 0; i < 8; i++) ovl_reg[i] <= ovl_next[i];
        end
    end

    assign pixel_out       = pixel_reg;
    assign pixel_valid_out = valid_reg;
    assign x_out           = x_reg;
    assign line_done_out   = done_reg;
    assign overflow_out    = overflow_reg;
endmodule

// File: tb/tb_pixel_mix_fifo.sv
// Directed bench for pixel_mix_fifo: a queue-based scanline model checked every cycle,
// plus literal expectations for each scenario.
module tb_pixel_mix_fifo;
    localparam int PIX_W = 2, SHADE_W = 2, DEPTH = 16, X_MAX = 160, NUM_OBP = 2;

    logic        clk = 0, rst = 0, tclk = 1, line_start = 0, pause = 0, bg_push = 0;
    logic [2:0]  fine = 0;
    logic [15:0] bg_row = 0, obj_row = 0;
    logic        bg_ready, obj_merge = 0, obj_prio = 0, bg_en = 1, obj_en = 1;
    logic        obj_pal = 0;
    logic [7:0]  bgp = 8'hE4;
    logic [7:0]  obp [NUM_OBP];
    logic [1:0]  pixel;
    logic        valid, done, ovf;
    logic [7:0]  x;

    int checks = 0, errors = 0;
    int seen[$];
    int done_cnt = 0;

    pixel_mix_fifo #(.PIX_W(PIX_W), .SHADE_W(SHADE_W), .DEPTH(DEPTH), .X_MAX(X_MAX),
                     .NUM_OBP(NUM_OBP)) dut (
        .clk_in(clk), .rst_in(rst), .tclk_in(tclk), .line_start_in(line_start),
        .fine_scroll_in(fine), .pause_in(pause), .bg_push_in(bg_push), .bg_row_in(bg_row),
        .bg_ready_out(bg_ready), .obj_merge_in(obj_merge), .obj_row_in(obj_row),
        .obj_pal_in(obj_pal), .obj_prio_in(obj_prio), .bg_enable_in(bg_en),
        .obj_enable_in(obj_en), .bgp_in(bgp), .obp_in(obp), .pixel_out(pixel),
        .pixel_valid_out(valid), .x_out(x), .line_done_out(done), .overflow_out(ovf)
    );

    always #5 clk = ~clk;

    // Behavioural model: a pixel queue, an 8-entry sprite overlay and a line cursor
    int  bgq[$];
    int  m_idx[8], m_pal[8], m_prio[8];
    bit  m_active, m_ovf, e_valid, e_done, m_rdy, m_pop;
    int  m_skip, m_x, e_pixel, mb, mo, mprio, mpal, pix;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bgq.delete();
            for (int i = 0; i < 8; i++) begin m_idx[i] = 0; m_pal[i] = 0; m_prio[i] = 0; end
            m_active = 0; m_skip = 0; m_x = 0; m_ovf = 0;
            e_pixel = 0; e_valid = 0; e_done = 0;
        end else begin
            e_valid = 0;
            e_done  = 0;
            if (tclk) begin
                if (line_start) begin
                    bgq.delete();
                    for (int i = 0; i < 8; i++) begin m_idx[i] = 0; m_pal[i] = 0; m_prio[i] = 0; end
                    m_x = 0; m_ovf = 0; m_skip = int'(fine); m_active = 1;
                end else begin
                    m_rdy = (bgq.size() <= DEPTH - 8);
                    m_pop = m_active && m_x < X_MAX && bgq.size() > 0 && !pause && !obj_merge;
                    if (obj_merge) begin
                        for (int i = 0; i < 8; i++) begin
                            pix = (int'(obj_row) >> ((7 - i) * 2)) & 3;
                            if (m_idx[i] == 0 && pix != 0) begin
                                m_idx[i] = pix; m_pal[i] = int'(obj_pal); m_prio[i] = int'(obj_prio);
                            end
                        end
                    end
                    if (m_pop) begin
                        mb = bgq.pop_front();
                        mo = m_idx[0]; mpal = m_pal[0]; mprio = m_prio[0];
                        for (int i = 0; i < 7; i++) begin
                            m_idx[i] = m_idx[i+1]; m_pal[i] = m_pal[i+1]; m_prio[i] = m_prio[i+1];
                        end
                        m_idx[7] = 0; m_pal[7] = 0; m_prio[7] = 0;
                        if (m_skip > 0) begin
                            m_skip--;
                        end else begin
                            if (!bg_en) mb = 0;
                            if (!obj_en) mo = 0;
                            if (mo != 0 && (mprio == 0 || mb == 0))
                                e_pixel = (int'(obp[mpal]) >> (2 * mo)) & 3;
                            else
                                e_pixel = (int'(bgp) >> (2 * mb)) & 3;
                            e_valid = 1;
                            m_x++;
                            e_done = (m_x == X_MAX);
                        end
                    end
                    if (bg_push) begin
                        if (m_rdy)
                            for (int i = 0; i < 8; i++) bgq.push_back((int'(bg_row) >> ((7 - i) * 2)) & 3);
                        else
                            m_ovf = 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("valid", int'(valid), int'(e_valid));
        chk("pixel", int'(pixel), e_pixel);
        chk("x_out", int'(x), m_x);
        chk("line_done", int'(done), int'(e_done));
        chk("overflow", int'(ovf), int'(m_ovf));
        chk("bg_ready", int'(bg_ready), (bgq.size() <= DEPTH - 8) ? 1 : 0);
        if (valid) seen.push_back(int'(pixel));
        if (done) done_cnt++;
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) nxt();
    endtask

    task automatic start_line(input logic [2:0] fs);
        line_start = 1; fine = fs; nxt(); line_start = 0;
    endtask

    task automatic push_row(input logic [15:0] r);
        bg_push = 1; bg_row = r; nxt(); bg_push = 0;
    endtask

    task automatic merge_row(input logic [15:0] r, input logic pal, input logic prio);
        obj_merge = 1; obj_row = r; obj_pal = pal; obj_prio = prio; nxt(); obj_merge = 0;
    endtask

    task automatic feed(input logic [15:0] row, input int stop_x);
        int n = 0;
        while (int'(x) < stop_x && n < 1000) begin
            bg_push = bg_ready; bg_row = row; nxt(); n++;
        end
        bg_push = 0;
        if (int'(x) < stop_x) chk("feed_timeout", int'(x), stop_x);
    endtask

    task automatic mix_case(input string nm, input logic [15:0] brow, input logic [15:0] orow,
                            input logic pal, input logic prio, input logic ben, input logic oen,
                            input int exp);
        pause = 1; bg_en = ben; obj_en = oen;
        start_line(0);
        push_row(brow);
        merge_row(orow, pal, prio);
        seen.delete();
        pause = 0; idle(12); pause = 1;
        chk({nm, "_count"}, seen.size(), 8);
        for (int i = 0; i < seen.size(); i++) chk(nm, seen[i], exp);
        bg_en = 1; obj_en = 1; pause = 0;
    endtask

    initial begin
        int bad;
        int exp2[4];
        exp2[0] = 3; exp2[1] = 0; exp2[2] = 1; exp2[3] = 2;
        obp[0] = 8'hE4;
        obp[1] = 8'h1B;
        #1 rst = 1;
        #1;
        chk("rst_valid", int'(valid), 0);
        chk("rst_pixel", int'(pixel), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_ready", int'(bg_ready), 1);
        #20 rst = 0;
        nxt();

        // Basic line: index-1 rows through bgp=E4
        seen.delete(); done_cnt = 0;
        start_line(0);
        feed(16'h5555, X_MAX);
        idle(20);
        chk("t1_strobes", seen.size(), 160);
        bad = 0;
        foreach (seen[i]) if (seen[i] != 1) bad++;
        chk("t1_pixels_not_1", bad, 0);
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_x_final", int'(x), 160);

        // Fine scroll of 3 over rows 0,1,2,3,0,1,2,3
        seen.delete(); done_cnt = 0;
        start_line(3);
        feed(16'h1B1B, X_MAX);
        idle(10);
        chk("t2_strobes", seen.size(), 160);
        chk("t2_done_pulses", done_cnt, 1);
        if (seen.size() >= 4)
            for (int i = 0; i < 4; i++) chk("t2_first_shades", seen[i], exp2[i]);

        // Earlier sprite wins over a later one
        pause = 1;
        start_line(0);
        push_row(16'h0000);
        merge_row(16'hAAAA, 1'b0, 1'b0);
        merge_row(16'hFFFF, 1'b1, 1'b0);
        seen.delete();
        pause = 0; idle(12); pause = 1;
        chk("t3_count", seen.size(), 8);
        for (int i = 0; i < seen.size(); i++) chk("t3_shade", seen[i], 2);
        pause = 0;

        // Priority, enables and second palette
        mix_case("t4_bg_over_obj", 16'h5555, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b1, 1);
        mix_case("t4_prio_bg0",    16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b1, 3);
        mix_case("t4_obj_disabled",16'h5555, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        mix_case("t4_obp1",        16'h0000, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        mix_case("t4_bg_disabled", 16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        mix_case("t4_obj_over_bg", 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b1, 1);

        // Overflow on a full FIFO, cleared by the next line start
        pause = 1;
        start_line(0);
        push_row(16'h5555);
        push_row(16'h5555);
        chk("t5_ready_full", int'(bg_ready), 0);
        push_row(16'h5555);
        chk("t5_overflow_set", int'(ovf), 1);
        start_line(0);
        chk("t5_overflow_clear", int'(ovf), 0);

        // Push and pop in the same cycle at count 8 leaves 15
        push_row(16'h5555);
        seen.delete();
        pause = 0; bg_push = 1; bg_row = 16'h5555; nxt(); bg_push = 0; pause = 1;
        chk("t5_simul_strobe", seen.size(), 1);
        chk("t5_simul_ready", int'(bg_ready), 0);
        pause = 0; idle(25);
        chk("t5_total_strobes", seen.size(), 16);

        // A merge blocks the pop in its cycle
        pause = 1;
        start_line(0);
        push_row(16'h5555);
        seen.delete();
        pause = 0; obj_merge = 1; obj_row = 16'h0000; nxt(); obj_merge = 0;
        chk("t5_merge_no_pop", seen.size(), 0);
        idle(12);
        chk("t5_after_merge", seen.size(), 8);

        // Asynchronous reset mid-line
        seen.delete(); done_cnt = 0;
        start_line(0);
        feed(16'h5555, 73);
        chk("t6_x_before", int'(x), 73);
        chk("t6_pixel_before", int'(pixel), 1);
        #1 rst = 1;
        #1;
        chk("t6_rst_valid", int'(valid), 0);
        chk("t6_rst_pixel", int'(pixel), 0);
        chk("t6_rst_x", int'(x), 0);
        chk("t6_rst_done", int'(done), 0);
        chk("t6_rst_ovf", int'(ovf), 0);
        chk("t6_rst_ready", int'(bg_ready), 1);
        nxt(); nxt();
        rst = 0;
        seen.delete(); done_cnt = 0;
        start_line(0);
        chk("t6_x_restart", int'(x), 0);
        feed(16'h5555, X_MAX);
        idle(5);
        chk("t6_strobes", seen.size(), 160);
        chk("t6_done_pulses", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
